// File: rtl/fxp_acc_stream.sv
// rtl/fxp_acc_stream.sv - streaming signed fixed-point frame accumulator (optional macro FXP_ACC_SAT_EN: saturate out_data on overflow)
module fxp_acc_stream #(
    parameter int W     = 16,
    parameter int GUARD = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W-1:0]     out_data,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf
);

    localparam int AW = W + GUARD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [W-1:0]    out_data_q, out_data_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic                   out_ovf_q, out_ovf_d;

    logic                   in_xfer;
    logic signed [AW-1:0]   ext;
    logic signed [AW-1:0]   sum;
    logic [CNT_W-1:0]       cnt_inc;
    logic [GUARD:0]         sum_upper;
    logic                   sum_ovf;
    logic signed [W-1:0]    sum_reduced;

    // Datapath: running sum, saturating sample count and range reduction of the frame sum
    always_comb begin
        in_xfer   = in_valid && in_ready_q;
        ext       = {{GUARD{in_data[W-1]}}, in_data};
        sum       = (state_q == S_IDLE) ? ext : acc_q + ext;
        if (state_q == S_IDLE) begin
            cnt_inc = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_inc = cnt_q;
        end else begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
        // The sum fits in W bits only when all bits from W-1 upward agree
        sum_upper = sum[AW-1:W-1];
        sum_ovf   = !((&sum_upper) || (~|sum_upper));
`ifdef FXP_ACC_SAT_EN
        if (sum_ovf) begin
            sum_reduced = sum[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_reduced = sum[W-1:0];
        end
`else
        sum_reduced = sum[W-1:0];
`endif
    end

    // Next-state and registered-output logic of the IDLE/ACC/DONE frame FSM
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_ACC: begin
                    in_ready_d = 1'b1;
                    if (in_xfer) begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                        if (in_last) begin
                            state_d     = S_DONE;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                            out_data_d  = sum_reduced;
                            out_cnt_d   = cnt_inc;
                            out_ovf_d   = sum_ovf;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset holds in_ready low until the first edge after release
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fxp_acc_stream.sv
// tb/tb_fxp_acc_stream.sv - scoreboard bench for fxp_acc_stream
module tb_fxp_acc_stream;

    localparam int W     = 16;
    localparam int GUARD = 4;
    localparam int CNT_W = 8;
    localparam int AW    = W + GUARD;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [CNT_W-1:0]    out_cnt;
    logic                out_ovf;

    always #5 clk = ~clk;

    fxp_acc_stream #(.W(W), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    typedef struct packed {
        logic [W-1:0]     data;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint fsum  = 0;
    int     fcnt  = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint s, input int n);
        exp_t               m;
        logic signed [AW-1:0] a;
        a     = s[AW-1:0];
        m.ovf = (a > 32767) || (a < -32768);
`ifdef FXP_ACC_SAT_EN
        if (m.ovf) m.data = (a < 0) ? 16'h8000 : 16'h7fff;
        else       m.data = a[W-1:0];
`else
        m.data = a[W-1:0];
`endif
        m.cnt = (n > 255) ? 8'd255 : 8'(n);
        return m;
    endfunction

    task automatic mon();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, $signed(e.data));
                chk("out_cnt", out_cnt, e.cnt);
                chk("out_ovf", out_ovf, e.ovf);
            end
        end
    endtask

    // Called at a falling edge: observe, then advance one rising edge
    task automatic cyc();
        mon();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int d, input bit last);
        bit ok;
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d[W-1:0];
        in_last  = last;
        do begin
            ok = in_ready;
            cyc();
            guard++;
        end while (!ok && guard < 50);
        if (!ok) chk("in_ready_timeout", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        fsum += d;
        fcnt++;
        if (last) begin
            sb.push_back(model(fsum, fcnt));
            chk("latency_valid", out_valid, 1);
            chk("done_in_ready", in_ready, 0);
            fsum = 0;
            fcnt = 0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() > 0 && g < 20) begin
            cyc();
            g++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_cnt"}, out_cnt, 0);
        chk({tag, "_ovf"}, out_ovf, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        cyc();
        chk_zero("reset");
        rst = 1'b0;
        chk("ir_after_rst", in_ready, 0);
        cyc();
        chk("ir_rise", in_ready, 1);

        // 1152 + 3200 = 4352 (34.0 in Q8.7)
        send(1152, 0);
        send(3200, 1);
        chk("q87_data", out_data, 4352);
        chk("q87_cnt", out_cnt, 2);
        drain();

        // positive overflow
        send(32767, 0);
        send(128, 1);
        chk("pos_ovf", out_ovf, 1);
`ifdef FXP_ACC_SAT_EN
        chk("pos_data", out_data, 32767);
`else
        chk("pos_data", out_data, -32641);
`endif
        drain();

        // negative overflow
        send(-32768, 0);
        send(-1, 1);
        chk("neg_ovf", out_ovf, 1);
`ifdef FXP_ACC_SAT_EN
        chk("neg_data", out_data, -32768);
`else
        chk("neg_data", out_data, 32767);
`endif
        drain();

        // input gap and output backpressure
        send(100, 0);
        repeat (3) cyc();
        out_ready = 1'b0;
        send(50, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_data", out_data, 150);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        drain();
        chk("idle_after_accept", in_ready, 1);

        // clr with a valid sample drops the frame and the sample
        send(10, 0);
        send(20, 0);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'sd30; in_last = 1'b0;
        cyc();
        clr = 1'b0; in_valid = 1'b0;
        fsum = 0; fcnt = 0;
        chk("clr_valid", out_valid, 0);
        chk("clr_in_ready", in_ready, 1);
        send(5, 1);
        chk("clr_next_data", out_data, 5);
        chk("clr_next_cnt", out_cnt, 1);
        drain();

        // clr with a last-marked sample produces no result
        clr = 1'b1; in_valid = 1'b1; in_data = 16'sd99; in_last = 1'b1;
        cyc();
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("clr_last_valid", out_valid, 0);
        cyc();
        chk("clr_last_valid2", out_valid, 0);

        // reset mid-frame
        send(1, 0);
        send(2, 0);
        rst = 1'b1;
        cyc();
        chk_zero("rst_mid");
        rst = 1'b0;
        fsum = 0; fcnt = 0;
        cyc();
        send(7, 1);
        chk("rst_next_data", out_data, 7);
        chk("rst_next_cnt", out_cnt, 1);
        drain();

        // reset during DONE discards the result
        out_ready = 1'b0;
        send(3, 1);
        rst = 1'b1;
        cyc();
        sb.delete();
        chk_zero("rst_done");
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) cyc();
        chk("rst_done_novalid", out_valid, 0);

        // counter saturation
        for (int i = 0; i < 260; i++) send(1, i == 259);
        chk("cnt_sat", out_cnt, 255);
        drain();

        // random short frames
        repeat (8) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) send(int'($urandom_range(0, 65535)) - 32768, i == len - 1);
            drain();
        end

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
